huff_sym_decoder: RTL and testbench
===================================

Name: huff_sym_decoder

Overview:
- Consumer stage directly downstream of the Huffman bit-buffer shift register.
- Inspects the buffered bits (shift_buf, bit_count) and matches one prefix code at a time.
- For each match it pulses shift_en/shift_len back to the buffer and emits the signed 4-bit symbol on a valid/ready interface.
- Flags invalid codes and truncated streams, and signals end-of-stream completion.

Parameters:
MAX_CODE, 9, buffer width and longest code length in bits.
CNT_W, 16, width of emitted-symbol counter.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
shift_buf  in  MAX_CODE  buffered bits; first-received bit at [0].
bit_count  in  4  number of valid bits in shift_buf (0..MAX_CODE).
stream_end  in  1  level; no further bits will be loaded.
shift_en  out  1  one-cycle pulse; buffer drops shift_len bits from [0].
shift_len  out  4  bits to drop (1, 4, 6 or 9); held while shift_en=1.
need_bits  out  1  current code is incomplete; upstream must load more bits.
sym  out  4  decoded symbol, two's complement (-8..7).
sym_valid  out  1  sym is valid; held until sym_ready.
sym_ready  in  1  downstream accepts sym.
err  out  1  sticky: invalid code, or truncated code at stream_end.
done  out  1  sticky: stream_end with empty buffer in S_MATCH.
sym_count  out  CNT_W  symbols accepted since reset; wraps at 2^CNT_W.

Behaviour:
- Code table, written in transmission order; leftmost bit is shift_buf[0].
  - 0→0
  - 1000→1, 1001→-2, 1010→-3, 1011→3, 1100→2, 1101→-4, 1110→-1
  - 111100→5, 111101→-5, 111111→4
  - 111110000→6, 111110001→-6, 111110010→-8, 111110011→7, 111110100→-7
  - 111110101, 111110110, 111110111 are invalid.
- Match outcomes:
  - complete: bit_count ≥ code length.
  - incomplete: the bits needed to decide are missing.
  - invalid: a complete 9-bit invalid pattern is present.
- Reset (async, reset_n=0): state=S_MATCH; shift_en=0, shift_len=0, sym=0, sym_valid=0, err=0, done=0, sym_count=0. Reset takes effect immediately, mid-operation included.
- FSM, all outputs registered except need_bits:
  - S_MATCH:
    - complete: shift_en←1, shift_len←len, sym←value, go S_SHIFT.
    - invalid: err←1, go S_ERR.
    - incomplete and stream_end=1:
      - bit_count=0: done←1, go S_DONE.
      - otherwise: err←1, go S_ERR.
    - else: stay in S_MATCH.
  - S_SHIFT: shift_en is high this cycle and the buffer consumes at the next edge. At that edge: shift_en←0, sym_valid←1, go S_OUT.
  - S_OUT:
    - sym_valid=1 and sym stable until sym_ready=1.
    - On handshake: sym_valid←0, sym_count←sym_count+1, go S_MATCH.
    - The buffer is not re-examined before S_MATCH, because bit_count is already updated.
  - S_ERR, S_DONE: terminal; exit only via reset. No further shift_en pulses.
- need_bits = (state==S_MATCH) & incomplete & ~stream_end (combinational).
- Latency:
  - Complete code seen at edge N → shift_en high N..N+1 → sym_valid high from N+1.
  - Minimum 3 cycles per symbol with sym_ready tied high.
- Upstream contract: the loader must not assert load_bits while shift_en=1. Load and shift are never simultaneous.
- bit_count > MAX_CODE never occurs; if it does, it is treated as MAX_CODE.

Decomposition:
- Package huff_pkg holds:
  - MAX_CODE.
  - Code-length constants LEN1=1, LEN4=4, LEN6=6, LEN9=9.
  - State enum S_MATCH/S_SHIFT/S_OUT/S_ERR/S_DONE.
  - Symbol lookup constants for the table above.
- Sub-module huff_code_match: purely combinational.
  - Inputs: shift_buf, bit_count.
  - Outputs: complete, incomplete, invalid, len[3:0], value[3:0].
- The top holds the FSM, output registers and counter.

Test Plan:
1. shift_buf[0]=0, bit_count=1, sym_ready=1 → shift_en one cycle with shift_len=1; next cycle sym=4'b0000, sym_valid=1; sym_count=1 after handshake.
2. shift_buf[3:0]=4'b0111 (code 1110), bit_count=4 → shift_len=4, sym=4'b1111 (-1). Then shift_buf[3:0]=4'b0011 (code 1100) → sym=4'b0010.
3. bit_count=3, bits 111 → need_bits=1 and no shift_en for 5 cycles. Raise bit_count=4 with bit3=0 → need_bits=0, shift_len=4, sym=-1.
4. shift_buf=9'b010011111 (code 111110010), bit_count=9 → shift_len=9, sym=4'b1000 (-8). Then 9'b110011111 (code 111110011) → sym=4'b0111.
5. shift_buf=9'b111011111 (code 111110111), bit_count=9 → err=1 within one cycle, shift_en never pulses, err stays 1. reset_n=0 → err=0 immediately.
6. Hold sym_ready=0 for 4 cycles after sym_valid → sym held stable, no shift_en, sym_count unchanged. Then:
   - stream_end=1 with bit_count=0 → done=1.
   - Separate run: stream_end=1 with bits "11", bit_count=2 → err=1, done=0.

Source files
------------

// File: rtl/huff_sym_decoder_pkg.sv
// Shared constants for the Huffman symbol decoder: buffer width, code
// lengths, FSM state encoding and the symbol lookup tables.
package huff_pkg;

    localparam int MAX_CODE = 9;

    localparam logic [3:0] LEN1 = 4'd1;
    localparam logic [3:0] LEN4 = 4'd4;
    localparam logic [3:0] LEN6 = 4'd6;
    localparam logic [3:0] LEN9 = 4'd9;

    typedef enum logic [2:0] {
        S_MATCH,
        S_SHIFT,
        S_OUT,
        S_ERR,
        S_DONE
    } state_t;

    // 4-bit codes 1xxx, indexed by the last three transmitted bits.
    // Entry 7 (code 1111) is an escape to longer codes and never used.
    localparam logic [7:0][3:0] SYM4_TAB = {
        4'h0,   // 1111 (escape)
        4'hF,   // 1110 -> -1
        4'hC,   // 1101 -> -4
        4'h2,   // 1100 ->  2
        4'h3,   // 1011 ->  3
        4'hD,   // 1010 -> -3
        4'hE,   // 1001 -> -2
        4'h1    // 1000 ->  1
    };

    // 6-bit codes 1111xy
    localparam logic [3:0] SYM6_00 = 4'h5;   // 111100 ->  5
    localparam logic [3:0] SYM6_01 = 4'hB;   // 111101 -> -5
    localparam logic [3:0] SYM6_11 = 4'h4;   // 111111 ->  4

    // 9-bit codes 111110xyz, indexed by xyz; tails above 4 are invalid.
    localparam logic [7:0][3:0] SYM9_TAB = {
        4'h0, 4'h0, 4'h0,
        4'h9,   // 100 -> -7
        4'h7,   // 011 ->  7
        4'h8,   // 010 -> -8
        4'hA,   // 001 -> -6
        4'h6    // 000 ->  6
    };
    localparam logic [2:0] LAST_VALID_TAIL9 = 3'd4;

endpackage

// File: rtl/huff_sym_decoder_code_match.sv
// Combinational prefix-code matcher. Walks the code tree from the first
// received bit (shift_buf[0]) and reports whether the buffered bits hold a
// complete code, need more bits, or form an invalid 9-bit pattern.
module huff_code_match
    import huff_pkg::*;
#(
    parameter int MAX_CODE_P = MAX_CODE
) (
    input  logic [MAX_CODE_P-1:0] shift_buf,
    input  logic [3:0]            bit_count,
    output logic                  complete,
    output logic                  incomplete,
    output logic                  invalid,
    output logic [3:0]            len,
    output logic [3:0]            value
);

    logic [3:0] n;
    logic [3:0] c4;
    logic [2:0] tail9;

    // Decode the tree level by level; each level needs its full length present.
    always_comb begin
        complete   = 1'b0;
        incomplete = 1'b0;
        invalid    = 1'b0;
        len        = 4'd0;
        value      = 4'd0;
        n          = (bit_count > 4'(MAX_CODE_P)) ? 4'(MAX_CODE_P) : bit_count;
        c4         = {shift_buf[0], shift_buf[1], shift_buf[2], shift_buf[3]};
        tail9      = {shift_buf[6], shift_buf[7], shift_buf[8]};

        if (n == 4'd0) begin
            incomplete = 1'b1;
        end else if (!shift_buf[0]) begin
            complete = 1'b1;
            len      = LEN1;
            value    = 4'd0;
        end else if (n < LEN4) begin
            incomplete = 1'b1;
        end else if (c4 != 4'b1111) begin
            complete = 1'b1;
            len      = LEN4;
            value    = SYM4_TAB[c4[2:0]];
        end else if (n < LEN6) begin
            incomplete = 1'b1;
        end else if (!(shift_buf[4] && !shift_buf[5])) begin
            complete = 1'b1;
            len      = LEN6;
            case ({shift_buf[4], shift_buf[5]})
                2'b00:   value = SYM6_00;
                2'b01:   value = SYM6_01;
                default: value = SYM6_11;
            endcase
        end else if (n < LEN9) begin
            incomplete = 1'b1;
        end else if (tail9 <= LAST_VALID_TAIL9) begin
            complete = 1'b1;
            len      = LEN9;
            value    = SYM9_TAB[tail9];
        end else begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/huff_sym_decoder.sv
// Huffman symbol decoder: matches one code at a time from the bit buffer,
// requests the shift, then presents the symbol on a valid/ready port.
//
// state   | meaning
// S_MATCH | inspect buffer; wait for bits, shift a code, or finish/fail
// S_SHIFT | shift_en high; buffer drops shift_len bits at the next edge
// S_OUT   | sym_valid high; wait for sym_ready
// S_ERR   | invalid or truncated code seen; held until reset
// S_DONE  | stream ended cleanly on a code boundary; held until reset
module huff_sym_decoder
    import huff_pkg::*;
#(
    parameter int MAX_CODE_P = MAX_CODE,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [MAX_CODE_P-1:0] shift_buf,
    input  logic [3:0]            bit_count,
    input  logic                  stream_end,
    output logic                  shift_en,
    output logic [3:0]            shift_len,
    output logic                  need_bits,
    output logic [3:0]            sym,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic                  err,
    output logic                  done,
    output logic [CNT_W-1:0]      sym_count
);

    state_t     state;
    state_t     state_nxt;
    logic       m_complete;
    logic       m_incomplete;
    logic       m_invalid;
    logic [3:0] m_len;
    logic [3:0] m_value;

    huff_code_match #(.MAX_CODE_P(MAX_CODE_P)) u_match (
        .shift_buf  (shift_buf),
        .bit_count  (bit_count),
        .complete   (m_complete),
        .incomplete (m_incomplete),
        .invalid    (m_invalid),
        .len        (m_len),
        .value      (m_value)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_MATCH;
        else          state <= state_nxt;
    end

    // Next-state decision; S_ERR and S_DONE only leave through reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_MATCH: begin
                if (m_complete)
                    state_nxt = S_SHIFT;
                else if (m_invalid)
                    state_nxt = S_ERR;
                else if (m_incomplete && stream_end)
                    state_nxt = (bit_count == 4'd0) ? S_DONE : S_ERR;
            end
            S_SHIFT: state_nxt = S_OUT;
            S_OUT:   if (sym_ready) state_nxt = S_MATCH;
            default: state_nxt = state;
        endcase
    end

    // Registered outputs, driven from the transition being taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_en  <= 1'b0;
            shift_len <= 4'd0;
            sym       <= 4'd0;
            sym_valid <= 1'b0;
            err       <= 1'b0;
            done      <= 1'b0;
            sym_count <= '0;
        end else begin
            shift_en <= (state == S_MATCH) && (state_nxt == S_SHIFT);
            if ((state == S_MATCH) && (state_nxt == S_SHIFT)) begin
                shift_len <= m_len;
                sym       <= m_value;
            end
            if ((state == S_MATCH) && (state_nxt == S_ERR))
                err <= 1'b1;
            if ((state == S_MATCH) && (state_nxt == S_DONE))
                done <= 1'b1;
            if (state == S_SHIFT)
                sym_valid <= 1'b1;
            if ((state == S_OUT) && sym_ready) begin
                sym_valid <= 1'b0;
                sym_count <= sym_count + CNT_W'(1);
            end
        end
    end

    // Upstream load request: only meaningful while matching and more bits can come.
    always_comb begin
        need_bits = (state == S_MATCH) && m_incomplete && !stream_end;
    end

endmodule

// File: tb/tb_huff_sym_decoder.sv
// Scoreboard bench for huff_sym_decoder: the driver acts as the bit buffer
// and pushes the expected {sym, shift_len} per code; a monitor pops on each
// accepted symbol and compares.
module tb_huff_sym_decoder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  shift_buf;
    logic [3:0]  bit_count;
    logic        stream_end;
    logic        shift_en;
    logic [3:0]  shift_len;
    logic        need_bits;
    logic [3:0]  sym;
    logic        sym_valid;
    logic        sym_ready;
    logic        err;
    logic        done;
    logic [15:0] sym_count;

    int         tests = 0;
    int         fails = 0;
    int         exp_count = 0;
    logic [7:0] exp_q[$];

    huff_sym_decoder #(.MAX_CODE_P(9), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift_buf  (shift_buf),
        .bit_count  (bit_count),
        .stream_end (stream_end),
        .shift_en   (shift_en),
        .shift_len  (shift_len),
        .need_bits  (need_bits),
        .sym        (sym),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .err        (err),
        .done       (done),
        .sym_count  (sym_count)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Present one code, wait for the shift, drop it from the buffer, wait for acceptance.
    task automatic send(input logic [8:0] pat, input logic [3:0] n,
                        input logic [3:0] esym, input logic [3:0] elen);
        bit got;
        exp_q.push_back({esym, elen});
        shift_buf = pat;
        bit_count = n;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (shift_en) begin got = 1'b1; break; end
        end
        check(got, "shift_en_seen", int'(got), 1);
        @(posedge clk); #1;
        shift_buf = '0;
        bit_count = 4'd0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sym_valid && sym_ready) begin got = 1'b1; break; end
        end
        check(got, "handshake_seen", int'(got), 1);
        @(posedge clk); #1;
        exp_count++;
        check(sym_count == 16'(exp_count), "sym_count", int'(sym_count), exp_count);
    endtask

    // Monitor: pops the scoreboard on every accepted symbol.
    initial begin : monitor
        logic       prev_se;
        logic       hold_valid;
        logic [3:0] hold_sym;
        logic [3:0] last_len;
        logic [7:0] e;
        prev_se    = 1'b0;
        hold_valid = 1'b0;
        hold_sym   = 4'd0;
        last_len   = 4'd0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_se    = 1'b0;
                hold_valid = 1'b0;
            end else begin
                if (shift_en) begin
                    check(!prev_se, "shift_en_width", int'(prev_se), 0);
                    last_len = shift_len;
                end
                prev_se = shift_en;
                if (sym_valid && hold_valid)
                    check(sym == hold_sym, "sym_stable", int'(sym), int'(hold_sym));
                if (sym_valid && sym_ready) begin
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_sym", int'(sym), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(sym == e[7:4], "sym_value", int'(sym), int'(e[7:4]));
                        check(last_len == e[3:0], "shift_len", int'(last_len), int'(e[3:0]));
                    end
                    hold_valid = 1'b0;
                end else if (sym_valid) begin
                    hold_valid = 1'b1;
                    hold_sym   = sym;
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        bit got;
        reset_n    = 1'b0;
        shift_buf  = '0;
        bit_count  = 4'd0;
        stream_end = 1'b0;
        sym_ready  = 1'b1;
        #12;
        check(shift_en == 1'b0,   "rst_shift_en",  int'(shift_en),  0);
        check(shift_len == 4'd0,  "rst_shift_len", int'(shift_len), 0);
        check(sym == 4'd0,        "rst_sym",       int'(sym),       0);
        check(sym_valid == 1'b0,  "rst_sym_valid", int'(sym_valid), 0);
        check(err == 1'b0,        "rst_err",       int'(err),       0);
        check(done == 1'b0,       "rst_done",      int'(done),      0);
        check(sym_count == 16'd0, "rst_sym_count", int'(sym_count), 0);
        check(need_bits == 1'b1,  "rst_need_bits", int'(need_bits), 1);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // 1-, 4-, 6- and 9-bit codes
        send(9'b000000000, 4'd1, 4'h0, 4'd1);   // 0         ->  0
        send(9'b000000111, 4'd4, 4'hF, 4'd4);   // 1110      -> -1
        send(9'b000000011, 4'd4, 4'h2, 4'd4);   // 1100      ->  2
        send(9'b000000001, 4'd4, 4'h1, 4'd4);   // 1000      ->  1
        send(9'b000101111, 4'd6, 4'hB, 4'd6);   // 111101    -> -5
        send(9'b000111111, 4'd6, 4'h4, 4'd6);   // 111111    ->  4
        send(9'b010011111, 4'd9, 4'h8, 4'd9);   // 111110010 -> -8
        send(9'b110011111, 4'd9, 4'h7, 4'd9);   // 111110011 ->  7
        send(9'b001011111, 4'd9, 4'h9, 4'd9);   // 111110100 -> -7

        // Partial code: must ask for bits and not shift
        shift_buf = 9'b000000111;
        bit_count = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(need_bits == 1'b1, "partial_need_bits", int'(need_bits), 1);
            check(shift_en == 1'b0,  "partial_no_shift",  int'(shift_en),  0);
        end
        @(posedge clk); #1;
        shift_buf = 9'b000000111;
        bit_count = 4'd4;
        #1;
        check(need_bits == 1'b0, "filled_need_bits", int'(need_bits), 0);
        send(9'b000000111, 4'd4, 4'hF, 4'd4);

        // Backpressure: symbol held while sym_ready is low
        sym_ready = 1'b0;
        exp_q.push_back({4'h3, 4'd4});          // 1011 -> 3
        shift_buf = 9'b000001101;
        bit_count = 4'd4;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (shift_en) begin got = 1'b1; break; end
        end
        check(got, "bp_shift_en_seen", int'(got), 1);
        @(posedge clk); #1;
        shift_buf = '0;
        bit_count = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(sym_valid == 1'b1, "bp_sym_valid", int'(sym_valid), 1);
            check(sym == 4'h3,       "bp_sym",       int'(sym),       3);
            check(shift_en == 1'b0,  "bp_no_shift",  int'(shift_en),  0);
            check(sym_count == 16'(exp_count), "bp_sym_count", int'(sym_count), exp_count);
        end
        @(posedge clk); #1;
        sym_ready = 1'b1;
        @(posedge clk); #1;
        exp_count++;
        check(sym_count == 16'(exp_count), "bp_sym_count_after", int'(sym_count), exp_count);
        check(sym_valid == 1'b0, "bp_valid_drop", int'(sym_valid), 0);

        // Clean end of stream
        stream_end = 1'b1;
        @(posedge clk); #1;
        check(done == 1'b1, "eos_done", int'(done), 1);
        check(err == 1'b0,  "eos_err",  int'(err),  0);
        repeat (3) @(posedge clk);
        #1;
        check(done == 1'b1, "eos_done_sticky", int'(done), 1);

        reset_n = 1'b0;
        #1;
        check(done == 1'b0,       "eos_rst_done",  int'(done),      0);
        check(sym_count == 16'd0, "eos_rst_count", int'(sym_count), 0);
        exp_count  = 0;
        stream_end = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Truncated code at end of stream
        shift_buf  = 9'b000000011;
        bit_count  = 4'd2;
        stream_end = 1'b1;
        @(posedge clk); #1;
        check(err == 1'b1,  "trunc_err",  int'(err),  1);
        check(done == 1'b0, "trunc_done", int'(done), 0);
        reset_n = 1'b0;
        #1;
        stream_end = 1'b0;
        shift_buf  = '0;
        bit_count  = 4'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Invalid 9-bit code; err is sticky and no shift occurs
        shift_buf = 9'b111011111;               // 111110111
        bit_count = 4'd9;
        @(posedge clk); #1;
        check(err == 1'b1, "inv_err", int'(err), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(shift_en == 1'b0, "inv_no_shift",   int'(shift_en), 0);
            check(err == 1'b1,      "inv_err_sticky", int'(err),      1);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check(err == 1'b0, "inv_rst_err", int'(err), 0);
        shift_buf = '0;
        bit_count = 4'd0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
